// File: rtl/monobit_pkg.sv
// Shared types and constants for the monobit entropy front end.
// FSM state encoding, default block length and counter sizing helper.
package monobit_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } fsm_t;

    localparam int BLOCK_LEN_DEF = 128;

    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/monobit_sync.sv
// Multi-flop synchroniser for one asynchronous input bit.
// Depth is SYNC_STAGES (2 or more); runs regardless of design enable.
module monobit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/monobit_frontend.sv
// Entropy front end: synchronise raw bits, frame into blocks, valid/ready out.
// Define VON_NEUMANN_EN to insert a von Neumann debiaser before framing.
module monobit_frontend
    import monobit_pkg::*;
#(
    parameter int BLOCK_LEN   = BLOCK_LEN_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw_bit,
    input  logic sample_en,
    input  logic start,
    output logic bit_out,
    output logic bit_valid,
    input  logic bit_ready,
    output logic block_last,
    output logic busy,
    output logic overrun
);

    localparam int CW = cnt_width(BLOCK_LEN);
    localparam logic [CW-1:0] LEN_C = CW'(BLOCK_LEN);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic s_raw;
    logic s_en;

    monobit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_raw (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_bit),
        .q     (s_raw)
    );

    monobit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sample_en),
        .q     (s_en)
    );

    fsm_t          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          bit_q, bit_d;
    logic          last_q, last_d;
    logic          ovr_q, ovr_d;
    logic          prev_q, prev_d;
    logic          samp_q, samp_d;
    logic          sbit_q, sbit_d;
`ifdef VON_NEUMANN_EN
    logic          pend_q, pend_d;
    logic          pbit_q, pbit_d;
`endif

    logic          accept;
    logic          produce;
    logic          prod_bit;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        bit_d    = bit_q;
        last_d   = last_q;
        ovr_d    = ovr_q;
        prev_d   = prev_q;
        samp_d   = samp_q;
        sbit_d   = sbit_q;
`ifdef VON_NEUMANN_EN
        pend_d   = pend_q;
        pbit_d   = pbit_q;
`endif
        accept   = valid_q & bit_ready;
        produce  = 1'b0;
        prod_bit = 1'b0;
        cnt_inc  = cnt_q + ONE_C;

        if (ena) begin
            // samp/sbit are registered so they stay paired with each other
            prev_d = s_en;
            samp_d = s_en & ~prev_q;
            sbit_d = s_raw;

            if (start) begin
                state_d = COLLECT;
                cnt_d   = '0;
                valid_d = 1'b0;
                bit_d   = 1'b0;
                last_d  = 1'b0;
                ovr_d   = 1'b0;
`ifdef VON_NEUMANN_EN
                pend_d  = 1'b0;
`endif
            end else begin
                if (accept) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                    end
                end

                if (state_q == COLLECT && samp_q && cnt_q != LEN_C) begin
`ifdef VON_NEUMANN_EN
                    if (pend_q) begin
                        pend_d   = 1'b0;
                        produce  = pbit_q ^ sbit_q;
                        prod_bit = pbit_q;
                    end else begin
                        pend_d = 1'b1;
                        pbit_d = sbit_q;
                    end
`else
                    produce  = 1'b1;
                    prod_bit = sbit_q;
`endif
                end

                // One-entry buffer: refill on the accepting cycle, else drop
                if (produce) begin
                    if (!valid_q || accept) begin
                        valid_d = 1'b1;
                        bit_d   = prod_bit;
                        last_d  = (cnt_inc == LEN_C);
                        cnt_d   = cnt_inc;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
            ovr_q   <= 1'b0;
            prev_q  <= 1'b0;
            samp_q  <= 1'b0;
            sbit_q  <= 1'b0;
`ifdef VON_NEUMANN_EN
            pend_q  <= 1'b0;
            pbit_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            ovr_q   <= ovr_d;
            prev_q  <= prev_d;
            samp_q  <= samp_d;
            sbit_q  <= sbit_d;
`ifdef VON_NEUMANN_EN
            pend_q  <= pend_d;
            pbit_q  <= pbit_d;
`endif
        end
    end

    assign bit_out    = bit_q;
    assign bit_valid  = valid_q;
    assign block_last = valid_q & last_q;
    assign busy       = (state_q == COLLECT);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_monobit_frontend.sv
// Directed self-checking bench for monobit_frontend (short blocks).
// Builds with or without VON_NEUMANN_EN; block length adapts to the mode.
module tb_monobit_frontend;

`ifdef VON_NEUMANN_EN
    localparam int BL = 3;
`else
    localparam int BL = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic raw_bit = 1'b0;
    logic sample_en = 1'b0;
    logic start = 1'b0;
    logic bit_ready = 1'b0;
    logic bit_out;
    logic bit_valid;
    logic block_last;
    logic busy;
    logic overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    monobit_frontend #(
        .BLOCK_LEN   (BL),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .raw_bit    (raw_bit),
        .sample_en  (sample_en),
        .start      (start),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .block_last (block_last),
        .busy       (busy),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic strobe(input logic b);
        raw_bit   = b;
        sample_en = 1'b1;
        cyc(2);
        sample_en = 1'b0;
        cyc(2);
    endtask

    task automatic get_bit(input string tag, input logic eb, input logic el);
        int n;
        n = 0;
        while (!bit_valid && n < 20) begin
            cyc(1);
            n++;
        end
        chk({tag, "_valid"}, bit_valid, 1'b1);
        chk({tag, "_bit"}, bit_out, eb);
        chk({tag, "_last"}, block_last, el);
        cyc(1);
    endtask

    task automatic no_bit(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            cyc(1);
            if (bit_valid) seen = 1'b1;
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        cyc(2);
        chk("rst_bit_out", bit_out, 1'b0);
        chk("rst_valid", bit_valid, 1'b0);
        chk("rst_last", block_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        ena = 1'b1;
        bit_ready = 1'b1;
        cyc(2);
        chk("idle_busy", busy, 1'b0);

`ifndef VON_NEUMANN_EN
        pulse_start();
        chk("dir_busy", busy, 1'b1);
        raw_bit = 1'b1;
        sample_en = 1'b1;
        cyc(2);
        sample_en = 1'b0;
        cyc(1);
        chk("lat_early", bit_valid, 1'b0);
        cyc(1);
        chk("lat_valid", bit_valid, 1'b1);
        chk("lat_bit", bit_out, 1'b1);
        chk("lat_last", block_last, 1'b0);
        cyc(1);
        strobe(1'b0);
        get_bit("dir2", 1'b0, 1'b0);
        strobe(1'b1);
        get_bit("dir3", 1'b1, 1'b0);
        strobe(1'b1);
        get_bit("dir4", 1'b1, 1'b1);
        chk("dir_busy_fall", busy, 1'b0);
        strobe(1'b1);
        no_bit("dir_5th", 8);

        bit_ready = 1'b0;
        pulse_start();
        strobe(1'b0);
        cyc(3);
        strobe(1'b1);
        cyc(4);
        chk("bp_valid", bit_valid, 1'b1);
        chk("bp_hold", bit_out, 1'b0);
        chk("bp_overrun", overrun, 1'b1);
        bit_ready = 1'b1;
        cyc(1);
        chk("bp_drain", bit_valid, 1'b0);
        no_bit("bp_one_only", 8);
        chk("bp_ovr_sticky", overrun, 1'b1);

        pulse_start();
        chk("rs_ovr_clr", overrun, 1'b0);
        chk("rs_busy", busy, 1'b1);
        strobe(1'b1);
        get_bit("rs_a1", 1'b1, 1'b0);
        strobe(1'b0);
        get_bit("rs_a2", 1'b0, 1'b0);
        pulse_start();
        strobe(1'b0);
        get_bit("rs_b1", 1'b0, 1'b0);
        strobe(1'b1);
        get_bit("rs_b2", 1'b1, 1'b0);
        strobe(1'b1);
        get_bit("rs_b3", 1'b1, 1'b0);
        strobe(1'b0);
        get_bit("rs_b4", 1'b0, 1'b1);
        chk("rs_busy_fall", busy, 1'b0);

        pulse_start();
        ena = 1'b0;
        strobe(1'b1);
        strobe(1'b0);
        no_bit("ena_low", 6);
        ena = 1'b1;
        cyc(3);
        strobe(1'b1);
        get_bit("ena_1", 1'b1, 1'b0);
        strobe(1'b0);
        get_bit("ena_2", 1'b0, 1'b0);
        strobe(1'b0);
        get_bit("ena_3", 1'b0, 1'b0);
        strobe(1'b1);
        get_bit("ena_4", 1'b1, 1'b1);
        chk("ena_busy_fall", busy, 1'b0);
`else
        pulse_start();
        chk("vn_busy", busy, 1'b1);
        strobe(1'b0);
        strobe(1'b1);
        get_bit("vn_01", 1'b0, 1'b0);
        strobe(1'b1);
        strobe(1'b1);
        no_bit("vn_11", 8);
        strobe(1'b1);
        strobe(1'b0);
        get_bit("vn_10", 1'b1, 1'b0);
        strobe(1'b0);
        strobe(1'b0);
        no_bit("vn_00", 8);
        strobe(1'b0);
        strobe(1'b1);
        get_bit("vn_01b", 1'b0, 1'b1);
        chk("vn_busy_fall", busy, 1'b0);
`endif

        bit_ready = 1'b0;
        pulse_start();
`ifdef VON_NEUMANN_EN
        strobe(1'b1);
        strobe(1'b0);
`else
        strobe(1'b1);
`endif
        cyc(3);
        chk("mid_valid", bit_valid, 1'b1);
        chk("mid_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bit_out", bit_out, 1'b0);
        chk("arst_valid", bit_valid, 1'b0);
        chk("arst_last", block_last, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_overrun", overrun, 1'b0);
        cyc(1);
        rst_n = 1'b1;
        cyc(5);
        chk("post_busy", busy, 1'b0);
        chk("post_valid", bit_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/monobit_frontend.md
# monobit_frontend

Entropy-input front end for the monobit frequency tester. It synchronises an off-chip raw random bit and its sample strobe, and optionally applies von Neumann debiasing. It frames the resulting bits into blocks of BLOCK_LEN and hands them one at a time, over a valid/ready handshake, to the monobit ones-counter inside tt_um_monobit.

## Interface
- BLOCK_LEN, 128, bits per test block; legal range 2..65535.
- SYNC_STAGES, 2, synchroniser depth for raw_bit and sample_en; legal range is 2 or more.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design enable; when low, all state holds.
- raw_bit  in  1  asynchronous entropy bit.
- sample_en  in  1  asynchronous sample strobe; each rising edge is one sample.
- start  in  1  synchronous one-cycle pulse that begins a new block.
- bit_out  out  1  delivered bit.
- bit_valid  out  1  bit_out is valid.
- bit_ready  in  1  downstream accepts the bit.
- block_last  out  1  qualifies bit_valid; marks the final bit of the block.
- busy  out  1  FSM is in COLLECT.
- overrun  out  1  sticky flag: a produced bit was dropped.

## Operation
- Synchronisers:
  - raw_bit and sample_en pass through identical SYNC_STAGES-flop chains, so the two stay aligned.
  - A rising edge on synced sample_en is detected with one extra flop and produces a `samp` pulse together with synced raw_bit `sbit`.
- FSM states:
  - IDLE: samples are ignored.
  - COLLECT: samples are processed.
  - IDLE to COLLECT on start.
  - COLLECT to IDLE when the bit with block_last is accepted (bit_valid && bit_ready).
- start in COLLECT restarts the block. It clears the count, the pending half-pair, the output register and overrun. start has priority over a coincident samp.
- Producer, without debiasing: each samp in COLLECT produces bit = sbit.
- Output register (one entry):
  - Loads the produced bit if the register is empty, or if it is being accepted in the same cycle.
  - If the register is full and not being accepted, the produced bit is dropped and overrun is set.
  - overrun clears only on start or reset.
- Block counter `cnt`, width $clog2(BLOCK_LEN+1):
  - Increments per bit loaded into the output register.
  - block_last is registered with the bit; it is set when the loaded bit is the BLOCK_LEN-th.
  - After the last bit is loaded, further samples are ignored until the FSM returns to IDLE.
- ena low freezes the FSM, counter, output register and edge detector. Synchroniser flops keep running.
- Reset values: bit_out 0, bit_valid 0, block_last 0, busy 0, overrun 0. State is IDLE, cnt is 0, the pending-pair flag is 0, and all synchroniser flops are 0.

## Timing
- samp asserts SYNC_STAGES+1 clock edges after the first clk edge that sees sample_en high.
- Without debiasing, bit_valid rises on the edge after samp (latency SYNC_STAGES+2 clocks).
- bit_valid and bit_out hold stable until accepted.
- Back-to-back acceptance sustains one bit per clock.
- busy falls on the edge that accepts the block_last bit.
- Reset is asynchronous on assertion. The design releases it to synchronous operation from the first clk edge after rst_n rises.

## Configuration
- VON_NEUMANN_EN defined:
  - Samples are paired. The first samp stores sbit and sets the pending flag.
  - The second samp compares: for pair (a,b) with a≠b, it produces bit a; equal pairs are discarded with no bit and no count.
  - Either way the pending flag clears.
  - Bit latency is measured from the second sample of the pair.
  - start clears the pending flag.
- Not defined: direct path as above. The pending-pair flop and comparator are absent.

## Structure
- Shared package monobit_pkg holds:
  - the FSM state enum fsm_t (IDLE, COLLECT);
  - the default BLOCK_LEN constant (128);
  - a function cnt_width(len) returning $clog2(len+1).
- One sub-module, monobit_sync: a parameterised SYNC_STAGES flop chain, instantiated twice (raw_bit, sample_en).
- FSM, debiaser, counter and output register stay in monobit_frontend.

## Test plan
- Reset mid-block:
  - Stimulus: rst_n low during COLLECT with bit_valid=1.
  - Required: all outputs 0 asynchronously; busy stays 0 until the next start.
- Direct path, BLOCK_LEN=4, bit_ready=1:
  - Stimulus: start, then 4 strobes with raw_bit 1,0,1,1.
  - Required: bits 1,0,1,1; block_last on the 4th only; busy falls after it; a 5th strobe gives no bit_valid.
- Backpressure:
  - Stimulus: bit_ready=0, then two strobes with raw_bit 0 then 1.
  - Required: bit_out holds 0; overrun=1; after bit_ready=1, exactly one bit is delivered; overrun stays set until start.
- Restart:
  - Stimulus: start after 2 of 4 bits.
  - Required: cnt restarts; block_last appears only after 4 further bits; overrun cleared.
- VON_NEUMANN_EN:
  - Stimulus: pairs 01,11,10,00,01.
  - Required: bits 0,1,0 delivered; equal pairs produce nothing; count is 3.
- ena low:
  - Stimulus: strobes issued while ena=0.
  - Required: no bit_valid and no count change; operation resumes normally once ena=1.
